// File: rtl/network_mac_requant_if.sv
// Product-in / activation-out stream bundle for network_mac_requant.
// The master side drives products, bias and out_tready. The slave side (the MAC) drives prod_tready and the output word.
interface network_mac_requant_if #(
  parameter int PROD_W = 30,
  parameter int OUT_W  = 16
);
  logic signed [PROD_W-1:0] prod_tdata;
  logic                     prod_tvalid;
  logic                     prod_tready;
  logic                     prod_tlast;
  logic signed [OUT_W-1:0]  bias;
  logic signed [OUT_W-1:0]  out_tdata;
  logic                     out_tvalid;
  logic                     out_tready;
  logic [1:0]               out_tuser;

  modport master (
    output prod_tdata, prod_tvalid, prod_tlast, bias, out_tready,
    input  prod_tready, out_tdata, out_tvalid, out_tuser
  );

  modport slave (
    input  prod_tdata, prod_tvalid, prod_tlast, bias, out_tready,
    output prod_tready, out_tdata, out_tvalid, out_tuser
  );
endinterface

// File: rtl/network_mac_requant.sv
// Bias-seeded product accumulator with round / shift / saturate requantization to 16-bit activations.
// Defining NETWORK_MAC_REQUANT_RELU_EN clamps negative results to zero after saturation.
module network_mac_requant #(
  parameter int PROD_W     = 30,
  parameter int ACC_W      = 42,
  parameter int OUT_W      = 16,
  parameter int FRAC_SHIFT = 13,
  parameter int MAX_TERMS  = 1024,
  parameter int CNT_W      = 11
) (
  input logic                  ap_clk,
  input logic                  ap_rst,
  network_mac_requant_if.slave bus
);

  localparam logic signed [ACC_W-1:0] HALF    = {{(ACC_W-1){1'b0}}, 1'b1} << (FRAC_SHIFT-1);
  localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]        LAST_BEAT = CNT_W'(MAX_TERMS-1);

  function automatic logic signed [ACC_W-1:0] round_shift(input logic signed [ACC_W-1:0] a);
    return (a + HALF) >>> FRAC_SHIFT;
  endfunction

  function automatic logic sat_flag(input logic signed [ACC_W-1:0] r);
    return (r > OUT_MAX) || (r < OUT_MIN);
  endfunction

  function automatic logic signed [OUT_W-1:0] sat_val(input logic signed [ACC_W-1:0] r);
    if (r > OUT_MAX)      return OUT_MAX[OUT_W-1:0];
    else if (r < OUT_MIN) return OUT_MIN[OUT_W-1:0];
    else                  return r[OUT_W-1:0];
  endfunction

  function automatic logic signed [OUT_W-1:0] relu(input logic signed [OUT_W-1:0] v);
`ifdef NETWORK_MAC_REQUANT_RELU_EN
    return v[OUT_W-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  logic signed [ACC_W-1:0] acc_p0;
  logic                    first_p0;
  logic [CNT_W-1:0]        cnt_p0;
  logic signed [OUT_W-1:0] out_data_p1;
  logic [1:0]              out_user_p1;
  logic                    vld_p1;

  logic                    tready;
  logic                    accept;
  logic                    terminal;
  logic signed [ACC_W-1:0] bias_ext;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [ACC_W-1:0] rnd;
  logic signed [OUT_W-1:0] res;
  logic                    sat;

  // Only a held, untaken result stalls the input; prod_tvalid never feeds back here.
  assign tready          = !(vld_p1 && !bus.out_tready);
  assign accept          = bus.prod_tvalid && tready;
  assign bus.prod_tready = tready;
  assign bus.out_tdata   = out_data_p1;
  assign bus.out_tuser   = out_user_p1;
  assign bus.out_tvalid  = vld_p1;

  always_comb begin
    bias_ext = {{(ACC_W-OUT_W){bus.bias[OUT_W-1]}}, bus.bias};
    prod_ext = {{(ACC_W-PROD_W){bus.prod_tdata[PROD_W-1]}}, bus.prod_tdata};
    acc_next = (first_p0 ? (bias_ext <<< FRAC_SHIFT) : acc_p0) + prod_ext;
    terminal = bus.prod_tlast || (cnt_p0 == LAST_BEAT);
    rnd      = round_shift(acc_next);
    sat      = sat_flag(rnd);
    res      = relu(sat_val(rnd));
  end

  // p0: accumulate; p1: requantized output register with valid/ready hold
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      acc_p0      <= '0;
      first_p0    <= 1'b1;
      cnt_p0      <= '0;
      out_data_p1 <= '0;
      out_user_p1 <= '0;
      vld_p1      <= 1'b0;
    end else begin
      if (accept) begin
        if (terminal) begin
          acc_p0      <= '0;
          first_p0    <= 1'b1;
          cnt_p0      <= '0;
          out_data_p1 <= res;
          out_user_p1 <= {!bus.prod_tlast, sat};
        end else begin
          acc_p0   <= acc_next;
          first_p0 <= 1'b0;
          cnt_p0   <= cnt_p0 + CNT_W'(1);
        end
      end
      if (accept && terminal) vld_p1 <= 1'b1;
      else if (bus.out_tready) vld_p1 <= 1'b0;
    end
  end

endmodule

// File: tb/tb_network_mac_requant.sv
// Bench for network_mac_requant (MAX_TERMS=4): vector table, backpressure, forced-termination and reset sequences, scoreboard on the output.
module tb_network_mac_requant;

  localparam int FRAC = 13;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  network_mac_requant_if #(.PROD_W(30), .OUT_W(16)) bus();

  network_mac_requant #(
    .PROD_W(30), .ACC_W(42), .OUT_W(16), .FRAC_SHIFT(FRAC), .MAX_TERMS(4), .CNT_W(3)
  ) dut (
    .ap_clk(clk),
    .ap_rst(rst),
    .bus(bus)
  );

  typedef struct {
    int n;
    int p0;
    int p1;
    int p2;
    int bias;
    int ed;
    int eu;
  } vec_t;

  typedef struct {
    int d;
    int u;
  } exp_t;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  vec_t vt[13];

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  function automatic int relu_exp(input int v);
`ifdef NETWORK_MAC_REQUANT_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  function automatic void model(input longint s, output int d, output int u);
    longint r;
    r = (s + (64'sd1 <<< (FRAC-1))) >>> FRAC;
    u = 0;
    if (r > 32767) begin r = 32767; u = 1; end
    else if (r < -32768) begin r = -32768; u = 1; end
    d = relu_exp(int'(r));
  endfunction

  function automatic exp_t mk(input int d, input int u);
    exp_t e;
    e.d = d;
    e.u = u;
    return e;
  endfunction

  task automatic send_beat(input int d, input bit last, input int b);
    bit rdy;
    int n;
    bus.prod_tdata  = d[29:0];
    bus.prod_tlast  = last;
    bus.bias        = b[15:0];
    bus.prod_tvalid = 1'b1;
    rdy = 1'b0;
    n = 0;
    while (!rdy && n < 100) begin
      @(negedge clk);
      rdy = bus.prod_tready;
      @(posedge clk);
      n++;
    end
    if (!rdy) begin
      checks++;
      failures++;
      $display("FAIL beat_accept_timeout: got tready=0 expected tready=1 within 100 cycles");
    end
    #1;
    bus.prod_tvalid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("scoreboard_drained", sb.size(), 0);
  endtask

  // Output monitor: compare each handshaken word against the queue head.
  always @(negedge clk) begin
    if (!rst && bus.out_tvalid && bus.out_tready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: got data %0d with empty scoreboard", bus.out_tdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_tdata", bus.out_tdata, e.d);
        chk("out_tuser", bus.out_tuser, e.u);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{1, 24576, 0, 0, 0, 3, 0};
    vt[1]  = '{3, 4096, 4096, 4096, 1, 3, 0};
    vt[2]  = '{2, 536870911, 536870911, 0, 0, 32767, 1};
    vt[3]  = '{2, -536870912, -536870912, 0, 0, relu_exp(-32768), 1};
    vt[4]  = '{1, -8192, 0, 0, -2, relu_exp(-3), 0};
    vt[5]  = '{1, 4096, 0, 0, 0, 1, 0};
    vt[6]  = '{1, 4095, 0, 0, 0, 0, 0};
    vt[7]  = '{1, -4096, 0, 0, 0, 0, 0};
    vt[8]  = '{1, -4097, 0, 0, 0, relu_exp(-1), 0};
    vt[9]  = '{1, 4095, 0, 0, 32767, 32767, 0};
    vt[10] = '{1, 4096, 0, 0, 32767, 32767, 1};
    vt[11] = '{1, -4096, 0, 0, -32768, relu_exp(-32768), 0};
    vt[12] = '{1, -4097, 0, 0, -32768, relu_exp(-32768), 1};

    bus.prod_tdata  = '0;
    bus.prod_tvalid = 1'b0;
    bus.prod_tlast  = 1'b0;
    bus.bias        = '0;
    bus.out_tready  = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_out_tvalid", bus.out_tvalid, 0);
    chk("rst_out_tdata", bus.out_tdata, 0);
    chk("rst_out_tuser", bus.out_tuser, 0);
    chk("rst_prod_tready", bus.prod_tready, 1);

    // Latency: result valid right after the accepting edge, gone one cycle later.
    @(posedge clk);
    #1;
    sb.push_back(mk(3, 0));
    send_beat(24576, 1'b1, 0);
    chk("latency_valid_after_1", bus.out_tvalid, 1);
    @(posedge clk);
    #1;
    chk("valid_drops_after_take", bus.out_tvalid, 0);
    drain();

    for (int i = 0; i < 13; i++) begin
      for (int k = 0; k < vt[i].n; k++) begin
        int p;
        bit last;
        p = (k == 0) ? vt[i].p0 : (k == 1) ? vt[i].p1 : vt[i].p2;
        last = (k == vt[i].n - 1);
        if (last) sb.push_back(mk(vt[i].ed, vt[i].eu));
        send_beat(p, last, (k == 0) ? vt[i].bias : ~vt[i].bias);
      end
    end
    drain();

    // Backpressure: first result held, second beat waits, then both move with no bubble.
    bus.out_tready = 1'b0;
    sb.push_back(mk(1, 0));
    send_beat(8192, 1'b1, 0);
    sb.push_back(mk(2, 0));
    bus.prod_tdata  = 30'sd16384;
    bus.prod_tlast  = 1'b1;
    bus.bias        = '0;
    bus.prod_tvalid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_prod_tready_low", bus.prod_tready, 0);
      chk("bp_hold_tdata", bus.out_tdata, 1);
      chk("bp_hold_tvalid", bus.out_tvalid, 1);
    end
    @(posedge clk);
    #1 bus.out_tready = 1'b1;
    @(negedge clk);
    chk("bp_prod_tready_high", bus.prod_tready, 1);
    @(posedge clk);
    #1 bus.prod_tvalid = 1'b0;
    chk("bp_b2b_tvalid", bus.out_tvalid, 1);
    chk("bp_b2b_tdata", bus.out_tdata, 2);
    drain();

    // Forced termination at MAX_TERMS, then a fresh packet with its own bias.
    for (int k = 0; k < 4; k++) begin
      if (k == 3) sb.push_back(mk(4, 2));
      send_beat(8192, 1'b0, (k == 0) ? 0 : 77);
    end
    send_beat(8192, 1'b0, 3);
    sb.push_back(mk(5, 0));
    send_beat(8192, 1'b1, 100);
    drain();

    // Reset mid-packet: partial sum discarded, nothing emitted.
    send_beat(8192, 1'b0, 5);
    send_beat(8192, 1'b0, 5);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rst_mid_no_output", bus.out_tvalid, 0);
    end
    @(posedge clk);
    #1;
    sb.push_back(mk(relu_exp(-3), 0));
    send_beat(-8192, 1'b1, -2);
    drain();

    // Random packets against the arithmetic model, with idle gaps inside packets.
    for (int i = 0; i < 10; i++) begin
      int     n;
      int     b;
      longint s;
      int     ed;
      int     eu;
      n = int'($urandom_range(1, 3));
      b = int'($urandom_range(0, 65535)) - 32768;
      s = longint'(b) <<< FRAC;
      for (int k = 0; k < n; k++) begin
        int p;
        p = int'($urandom_range(0, 2097151)) - 1048576;
        s = s + longint'(p);
        if (k == n - 1) begin
          model(s, ed, eu);
          sb.push_back(mk(ed, eu));
        end
        send_beat(p, k == n - 1, (k == 0) ? b : ~b);
        if ($urandom_range(0, 1) == 1) begin
          bus.prod_tdata = 30'sd12345;
          bus.prod_tlast = 1'b1;
          @(posedge clk);
          #1;
        end
      end
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
